// File: rtl/cic_decimator.sv
// N-stage CIC decimation filter: integrators at input rate, R:1 decimation, combs with delay M.
// All arithmetic is modular NOUT bits; integrator wrap-around is cancelled by the combs.
module cic_decimator #(
   parameter int unsigned NIN  = 12,
   parameter int unsigned N    = 3,
   parameter int unsigned R    = 8,
   parameter int unsigned M    = 1,
   parameter int unsigned NOUT = 21
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   i_clr,
   input  logic                   i_en,
   input  logic signed [NIN-1:0]  i_din,
   output logic                   o_valid,
   output logic signed [NOUT-1:0] o_dout
);

   localparam int unsigned CW = $clog2(R);
   localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

   if (NOUT != NIN + N * $clog2(R * M)) begin : g_bad_nout
      $error("cic_decimator: NOUT must equal NIN + N*clog2(R*M)");
   end
   if (N < 1 || N > 6) begin : g_bad_n
      $error("cic_decimator: N must be in 1..6");
   end
   if (R < 2 || R > 1024) begin : g_bad_r
      $error("cic_decimator: R must be in 2..1024");
   end
   if (M < 1 || M > 2) begin : g_bad_m
      $error("cic_decimator: M must be 1 or 2");
   end

   logic signed [NOUT-1:0] r_integ [N];
   logic        [N-1:0]    r_istb;
   logic        [CW-1:0]   r_cnt;
   logic signed [NOUT-1:0] r_comb  [N];
   logic signed [NOUT-1:0] r_dly   [N][M];
   logic        [N-1:0]    r_cstb;

   logic signed [NOUT-1:0] w_din_ext;
   logic                   w_iv;
   logic                   w_cs;
   logic        [N-1:0]    w_cstb;
   logic signed [NOUT-1:0] w_cx    [N];

   assign w_din_ext = {{(NOUT - NIN){i_din[NIN-1]}}, i_din};
   assign w_iv      = r_istb[N-1];
   assign w_cs      = w_iv && (r_cnt == CNT_LAST);

   // Comb stage j fires on the decimation strobe delayed j cycles and eats stage j-1's result.
   always_comb begin
      w_cstb[0] = w_cs;
      w_cx[0]   = r_integ[N-1];
      for (int j = 1; j < N; j++) begin
         w_cstb[j] = r_cstb[j-1];
         w_cx[j]   = r_comb[j-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_istb <= '0;
         r_cstb <= '0;
         r_cnt  <= '0;
         for (int j = 0; j < N; j++) begin
            r_integ[j] <= '0;
            r_comb[j]  <= '0;
            for (int i = 0; i < M; i++) r_dly[j][i] <= '0;
         end
      end else if (i_clr) begin
         r_istb <= '0;
         r_cstb <= '0;
         r_cnt  <= '0;
         for (int j = 0; j < N; j++) begin
            r_integ[j] <= '0;
            r_comb[j]  <= '0;
            for (int i = 0; i < M; i++) r_dly[j][i] <= '0;
         end
      end else begin
         r_istb[0] <= i_en;
         r_cstb[0] <= w_cs;
         for (int k = 1; k < N; k++) begin
            r_istb[k] <= r_istb[k-1];
            r_cstb[k] <= r_cstb[k-1];
         end

         if (i_en) r_integ[0] <= r_integ[0] + w_din_ext;
         for (int k = 1; k < N; k++) begin
            if (r_istb[k-1]) r_integ[k] <= r_integ[k] + r_integ[k-1];
         end

         if (w_iv) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);

         for (int j = 0; j < N; j++) begin
            if (w_cstb[j]) begin
               r_comb[j]   <= w_cx[j] - r_dly[j][M-1];
               r_dly[j][0] <= w_cx[j];
               for (int i = 1; i < M; i++) r_dly[j][i] <= r_dly[j][i-1];
            end
         end
      end
   end

   assign o_dout  = r_comb[N-1];
   assign o_valid = r_cstb[N-1];

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: default instance (N=3,R=8,M=1) plus an N=4,R=16,M=2 instance.
module tb_cic_decimator;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic clr = 1'b0, en = 1'b0;
   logic signed [11:0] din = '0;
   logic valid;
   logic signed [20:0] dout;
   logic clr2 = 1'b0, en2 = 1'b0;
   logic signed [11:0] din2 = '0;
   logic valid2;
   logic signed [31:0] dout2;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic signed [20:0] q_out[$];
   int q_cyc[$];
   logic signed [31:0] q_out2[$];
   int ref_seq[6] = '{120, 456, 512, 512, 512, 512};

   cic_decimator u_dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (clr),
      .i_en    (en),
      .i_din   (din),
      .o_valid (valid),
      .o_dout  (dout)
   );

   cic_decimator #(.NIN(12), .N(4), .R(16), .M(2), .NOUT(32)) u_dut2 (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (clr2),
      .i_en    (en2),
      .i_din   (din2),
      .o_valid (valid2),
      .o_dout  (dout2)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (valid) begin
         q_out.push_back(dout);
         q_cyc.push_back(cyc);
      end
      if (valid2) q_out2.push_back(dout2);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // gap < 0 picks a random 0..4 idle cycles after each sample.
   task automatic feed(input int n, input logic signed [11:0] v, input int gap, output int en8);
      en8 = -1;
      for (int i = 0; i < n; i++) begin
         en  = 1'b1;
         din = v;
         if (i == 7) en8 = cyc;
         tick(1);
         en = 1'b0;
         if (gap > 0) tick(gap);
         else if (gap < 0) tick(int'($urandom_range(0, 4)));
      end
      en = 1'b0;
   endtask

   task automatic clear_all();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      q_out.delete();
      q_cyc.delete();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (valid !== 1'b0 || dout !== 21'sd0) begin
         errors++;
         $display("FAIL reset_hold: valid=%b dout=%0d, want 0/0", valid, dout);
      end
      #3 rstn = 1'b1;
      tick(2);
      checks++;
      if (valid !== 1'b0 || dout !== 21'sd0) begin
         errors++;
         $display("FAIL reset_release: valid=%b dout=%0d, want 0/0", valid, dout);
      end
   endtask

   task automatic test_dc_unit();
      int en8, bad, bad_sp;
      q_out.delete();
      q_cyc.delete();
      feed(200, 12'sd1, 0, en8);
      tick(20);
      checks++;
      if (q_out.size() != 25) begin
         errors++;
         $display("FAIL dc1_count: got %0d outputs, want 25", q_out.size());
      end
      if (q_out.size() >= 25) begin
         // valid lands in the 7th negedge after the 8th strobe is driven: 2N cycles of latency
         checks++;
         if (q_cyc[0] !== en8 + 7) begin
            errors++;
            $display("FAIL dc1_latency: first valid cycle %0d, want %0d", q_cyc[0], en8 + 7);
         end
         bad = 0;
         bad_sp = 0;
         for (int i = 0; i < 25; i++) begin
            if (int'(q_out[i]) !== ((i < 6) ? ref_seq[i] : 512)) bad++;
            if (i > 0 && q_cyc[i] - q_cyc[i-1] != 8) bad_sp++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL dc1_values: %0d wrong, out0=%0d out1=%0d out3=%0d, want 120/456/512",
                     bad, q_out[0], q_out[1], q_out[3]);
         end
         checks++;
         if (bad_sp != 0) begin
            errors++;
            $display("FAIL dc1_spacing: %0d gaps differ from 8 cycles", bad_sp);
         end
      end
   endtask

   task automatic test_extremes();
      int en8;
      clear_all();
      feed(40, -12'sd2048, 0, en8);
      tick(12);
      checks++;
      if (q_out.size() != 5 || int'(q_out[3]) !== -1048576 || int'(q_out[4]) !== -1048576) begin
         errors++;
         $display("FAIL dc_min: n=%0d out3=%0d out4=%0d, want 5/-1048576", q_out.size(),
                  q_out[3], q_out[4]);
      end
      clear_all();
      feed(40, 12'sd2047, 0, en8);
      tick(12);
      checks++;
      if (q_out.size() != 5 || int'(q_out[3]) !== 1048064 || int'(q_out[4]) !== 1048064) begin
         errors++;
         $display("FAIL dc_max: n=%0d out3=%0d out4=%0d, want 5/1048064", q_out.size(),
                  q_out[3], q_out[4]);
      end
   endtask

   task automatic test_impulse();
      int en8, sum;
      clear_all();
      feed(1, 12'sd1, 0, en8);
      feed(63, 12'sd0, 0, en8);
      tick(12);
      sum = 0;
      foreach (q_out[i]) sum += int'(q_out[i]);
      checks++;
      if (q_out.size() != 8 || sum != 64) begin
         errors++;
         $display("FAIL impulse_sum: n=%0d sum=%0d, want 8/64", q_out.size(), sum);
      end
      checks++;
      if (q_out.size() == 8 && (q_out[6] !== 21'sd0 || q_out[7] !== 21'sd0)) begin
         errors++;
         $display("FAIL impulse_tail: out6=%0d out7=%0d, want 0/0", q_out[6], q_out[7]);
      end
   endtask

   task automatic test_sparse();
      int en8, bad;
      for (int pass = 0; pass < 2; pass++) begin
         clear_all();
         feed(40, 12'sd5, (pass == 0) ? 2 : -1, en8);
         tick(12);
         bad = 0;
         for (int i = 0; i < 5 && i < q_out.size(); i++)
            if (int'(q_out[i]) !== 5 * ref_seq[i]) bad++;
         checks++;
         if (q_out.size() != 5 || bad != 0) begin
            errors++;
            $display("FAIL sparse_values pass%0d: n=%0d bad=%0d last=%0d, want 5/0/2560", pass,
                     q_out.size(), bad, (q_out.size() > 0) ? q_out[q_out.size()-1] : 21'sd0);
         end
         if (pass == 0 && q_cyc.size() >= 2) begin
            checks++;
            if (q_cyc[1] - q_cyc[0] != 24) begin
               errors++;
               $display("FAIL sparse_spacing: %0d cycles, want 24", q_cyc[1] - q_cyc[0]);
            end
         end
      end
   endtask

   task automatic test_clear_midstream();
      int en8, bad;
      clear_all();
      feed(18, 12'sd1, 0, en8);
      // a valid for sample 16 is still in flight here; clr must cancel it and drop this en
      clr = 1'b1;
      en  = 1'b1;
      din = 12'sd1;
      tick(1);
      clr = 1'b0;
      en  = 1'b0;
      q_out.delete();
      q_cyc.delete();
      checks++;
      if (valid !== 1'b0 || dout !== 21'sd0) begin
         errors++;
         $display("FAIL clr_state: valid=%b dout=%0d, want 0/0", valid, dout);
      end
      feed(48, 12'sd1, 0, en8);
      tick(12);
      checks++;
      if (q_cyc.size() == 0 || q_cyc[0] !== en8 + 7) begin
         errors++;
         $display("FAIL clr_first_valid: cycle %0d, want %0d", (q_cyc.size() > 0) ? q_cyc[0] : -1,
                  en8 + 7);
      end
      bad = 0;
      for (int i = 0; i < 6 && i < q_out.size(); i++)
         if (int'(q_out[i]) !== ref_seq[i]) bad++;
      checks++;
      if (q_out.size() != 6 || bad != 0) begin
         errors++;
         $display("FAIL clr_sequence: n=%0d bad=%0d, want 6/0", q_out.size(), bad);
      end
   endtask

   task automatic test_async_reset();
      int en8;
      clear_all();
      feed(30, 12'sd1, 0, en8);
      tick(4);
      checks++;
      if (dout !== 21'sd512) begin
         errors++;
         $display("FAIL arst_pre: dout=%0d, want 512", dout);
      end
      en  = 1'b1;
      din = 12'sd1;
      #3 rstn = 1'b0;
      #1;
      checks++;
      if (valid !== 1'b0 || dout !== 21'sd0) begin
         errors++;
         $display("FAIL arst_now: valid=%b dout=%0d, want 0/0", valid, dout);
      end
      #2 rstn = 1'b1;
      en = 1'b0;
      tick(1);
      q_out.delete();
      q_cyc.delete();
      feed(24, 12'sd1, 0, en8);
      tick(12);
      checks++;
      if (q_out.size() != 3 || int'(q_out[0]) !== 120 || int'(q_out[2]) !== 512) begin
         errors++;
         $display("FAIL arst_restart: n=%0d out0=%0d, want 3/120", q_out.size(),
                  (q_out.size() > 0) ? q_out[0] : 21'sd0);
      end
   endtask

   task automatic test_param_sweep();
      int bad;
      q_out2.delete();
      for (int i = 0; i < 224; i++) begin
         en2  = 1'b1;
         din2 = 12'sd1;
         tick(1);
      end
      en2 = 1'b0;
      tick(20);
      checks++;
      if (q_out2.size() != 14) begin
         errors++;
         $display("FAIL sweep_count: got %0d outputs, want 14", q_out2.size());
      end
      bad = 0;
      for (int i = 9; i < q_out2.size(); i++)
         if (q_out2[i] !== 32'sd1048576) bad++;
      checks++;
      if (q_out2.size() < 14 || bad != 0) begin
         errors++;
         $display("FAIL sweep_settled: bad=%0d last=%0d, want 0/1048576", bad,
                  (q_out2.size() > 0) ? q_out2[q_out2.size()-1] : 32'sd0);
      end
   endtask

   initial begin
      test_reset();
      test_dc_unit();
      test_extremes();
      test_impulse();
      test_sparse();
      test_clear_midstream();
      test_async_reset();
      test_param_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Parametrised N-stage CIC decimation filter: N cascaded integrators at the input rate, an R:1 decimator, and N cascaded comb stages with differential delay M at the output rate. It sits behind the ADC/NCO front end and replaces the fixed 3-stage unsigned integrator. This version adds signed input, configurable order, decimation ratio and differential delay, a synchronous clear, and the comb/decimation section.

## Interface
- NIN, 12, input sample width (signed two's complement)
- N, 3, filter order (integrator and comb stage count), 1..6
- R, 8, decimation ratio, 2..1024
- M, 1, comb differential delay, 1 or 2
- NOUT, 21, output/accumulator width; must equal NIN + N*clog2(R*M); elaboration fails otherwise
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of all filter state
- en  in  1  input sample strobe; din valid when high
- din  in  NIN  signed input sample
- valid  out  1  one-cycle pulse, dout holds a new decimated sample
- dout  out  NOUT  signed filter output

## Operation
- din sign-extended to NOUT bits (not zero-extended).
- Integrator chain: stage 0 adds the extended din on en; stage k (k≥1) adds stage k-1 output when the en strobe delayed k cycles is high. Strobe delay line is N bits.
- Integrator valid (iv) = strobe delayed N cycles, aligned with the last integrator register update.
- Decimation counter: 0..R-1, advances on each iv, wraps R-1→0. Comb strobe cs fires on iv with counter == R-1.
- Comb stage j: on its strobe, c_j <= x_j - d_j[M-1]; delay line d_j shifts in x_j. x_0 = last integrator output; x_j = c_{j-1}. Comb strobe delayed one cycle per stage.
- dout = last comb register; valid = comb strobe delayed N cycles (aligned with last comb update).
- All adders/subtractors modular NOUT bits; integrator wrap-around is required and expected; no saturation. Output exact whenever the true result fits in NOUT signed bits (guaranteed by NOUT rule).
- DC gain (R*M)^N; for defaults 512.
- clr: on the clock edge with clr high, all integrators, comb registers, comb delays, strobe pipelines and decimation counter go to 0; en in the same cycle is dropped; any in-flight valid is cancelled.
- Reset: identical state to clr, asynchronously.

## Timing
- Reset values: valid = 0, dout = 0; all internal state 0.
- en may be high every cycle or arbitrarily sparse; result independent of gaps.
- en sampled at edge t: integrator stage k updated at edge t+1+k; iv visible after edge t+N.
- Decimating sample (R-th after clear/reset, then every R-th): comb stage 0 updated at edge t+N+1, last comb at edge t+2N; valid high for exactly the cycle after edge t+2N. Latency 2N cycles (6 for defaults).
- Back-to-back en: at most one valid per R samples; pipelines accept a new strobe every cycle, no stall.
- First output after clear/reset appears after R samples; first N*M outputs are startup transient.
- clr mid-pipeline: no valid after the clr edge until R fresh samples pass through.

## Test plan
- Reset then DC din=1 on every cycle for 200 cycles -> first valid 2N=6 cycles after 8th en; outputs settle to 512 by 4th output and stay 512; valid spacing exactly 8 cycles.
- DC din=-2048 continuous -> settled dout = -1048576 (21-bit minimum, exact, despite integrator wrap); din=2047 -> 1048064.
- Impulse din=1 once then zeros, continuous en -> sum of all subsequent outputs = 64, then dout stays 0.
- DC din=5 with en every 3rd cycle (random gaps in second pass) -> settled dout = 2560; valid spacing 24 cycles; same output sequence as continuous case.
- Assert clr for one cycle mid-stream, with en high that cycle -> next cycle dout/internal state 0, no valid for the next 8 samples +6 cycles; post-clear sequence identical to post-reset sequence.
- Deassert rstn asynchronously between edges mid-operation -> valid and dout 0 immediately; parameter sweep N=4,R=16,M=2 (NOUT=32) with DC din=1 -> settled dout = 1048576.
